tank_irrigation_ctrl: RTL and testbench

Controller for the irrigation tank. It takes the raw H/M/L water-level sensor bits, debounces them, and decodes them into a level code. It then sequences the two valves: the inlet valve fills the tank, and the irrigation outlet valve waters the field on request. It sits between the level-sensor/level-register path and the valve drivers, and flags inconsistent sensor readings and stuck fills as errors.

---
 rtl/tank_irrigation_ctrl.sv | 146 ++++++++++++++
 tb/tb_tank_irrigation_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tank_irrigation_ctrl.sv
// Irrigation tank controller: debounces the H/M/L level sensors, decodes a level
// code and sequences the inlet and irrigation valves, flagging bad readings and stuck fills.
module tank_irrigation_ctrl #(
  parameter int DEB_CYCLES   = 4,
  parameter int IRR_TIME     = 16,
  parameter int FILL_TIMEOUT = 64,
  parameter int TW           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       H,
  input  logic       M,
  input  logic       L,
  input  logic       irr_req,
  input  logic       err_clr,
  output logic       valve_in,
  output logic       valve_out,
  output logic [1:0] level,
  output logic       busy,
  output logic       err
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] IRR_LOAD  = TW'(IRR_TIME - 1);
  localparam logic [TW-1:0] FILL_LAST = TW'(FILL_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_IRRIG = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      sync_q;
  logic [2:0]      deb_q;
  logic [DW-1:0]   deb_cnt [3];
  logic [DW-1:0]   dv_cnt;
  logic            dvalid;
  logic [1:0]      level_cur;
  logic [1:0]      level_hold;
  logic            invalid;
  logic            level_up;
  logic [TW-1:0]   fill_cnt;
  logic [TW-1:0]   irr_timer;

  // Synchroniser keeps sampling through reset so debounce starts from live sensor data.
  always_ff @(posedge clk) begin
    sync_q <= {H, M, L};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_q <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync_q[i] == deb_q[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb_q[i]   <= sync_q[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dv_cnt <= '0;
      dvalid <= 1'b0;
    end else if (!dvalid) begin
      if (dv_cnt == DEB_LAST) dvalid <= 1'b1;
      else                    dv_cnt <= dv_cnt + DW'(1);
    end
  end

  // Thermometer decode; non-thermometer patterns keep the last good level.
  always_comb begin
    invalid   = 1'b0;
    level_cur = level_hold;
    case (deb_q)
      3'b000:  level_cur = 2'd0;
      3'b001:  level_cur = 2'd1;
      3'b011:  level_cur = 2'd2;
      3'b111:  level_cur = 2'd3;
      default: invalid   = 1'b1;
    endcase
  end

  assign level    = level_cur;
  assign level_up = (level_cur > level_hold);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (dvalid) begin
          if (invalid)                 state_d = S_ERROR;
          else if (level_cur <= 2'd1)  state_d = S_FILL;
          else if (irr_req)            state_d = S_IRRIG;
        end
      end
      S_FILL: begin
        if (invalid)                   state_d = S_ERROR;
        else if (level_cur == 2'd3)    state_d = S_IDLE;
        else if (fill_cnt == FILL_LAST) state_d = S_ERROR;
      end
      S_IRRIG: begin
        if (invalid)                   state_d = S_ERROR;
        else if (level_cur <= 2'd1)    state_d = S_IDLE;
        else if (irr_timer == '0)      state_d = S_IDLE;
      end
      S_ERROR: begin
        if (err_clr && !invalid)       state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The fill watchdog restarts whenever the water climbs a step.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      level_hold <= 2'd0;
      fill_cnt   <= '0;
      irr_timer  <= '0;
    end else begin
      state_q    <= state_d;
      level_hold <= level_cur;
      if (state_d == S_FILL && state_q != S_FILL) fill_cnt <= '0;
      else if (state_q == S_FILL)                 fill_cnt <= level_up ? '0 : fill_cnt + TW'(1);
      if (state_d == S_IRRIG && state_q != S_IRRIG)     irr_timer <= IRR_LOAD;
      else if (state_q == S_IRRIG && irr_timer != '0)   irr_timer <= irr_timer - TW'(1);
    end
  end

  assign valve_in  = (state_q == S_FILL);
  assign valve_out = (state_q == S_IRRIG);
  assign busy      = (state_q == S_FILL) || (state_q == S_IRRIG);
  assign err       = (state_q == S_ERROR);

endmodule

// File: tb/tb_tank_irrigation_ctrl.sv
// Self-checking bench for tank_irrigation_ctrl: directed vector table, fill-timeout
// sequences and randomized sensor traffic compared against an event-based reference model.
module tb_tank_irrigation_ctrl;

  localparam int DEB = 4;
  localparam int IRR = 16;
  localparam int FTO = 64;

  logic       clk = 1'b0;
  logic       rst, H, M, L, irr_req, err_clr;
  logic       valve_in, valve_out, busy, err;
  logic [1:0] level;

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b0;

  tank_irrigation_ctrl #(
    .DEB_CYCLES(DEB), .IRR_TIME(IRR), .FILL_TIMEOUT(FTO), .TW(8)
  ) dut (
    .clk(clk), .rst(rst), .H(H), .M(M), .L(L),
    .irr_req(irr_req), .err_clr(err_clr),
    .valve_in(valve_in), .valve_out(valve_out),
    .level(level), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Drive inputs at the current falling edge, then let the given number of cycles pass.
  task automatic applyStimulus(input logic [2:0] sens, input logic req, input logic clr, input int cycles);
    {H, M, L} = sens;
    irr_req   = req;
    err_clr   = clr;
    repeat (cycles) @(negedge clk);
  endtask

  // Reference model: sensor history window, level bookkeeping and edge timestamps.
  typedef enum {M_IDLE, M_FILL, M_IRRIG, M_ERROR} mstate_t;
  mstate_t    m_state = M_IDLE;
  logic [2:0] m_deb = 3'b000;
  logic [2:0] m_hist[$];
  bit         m_dvalid = 1'b0;
  int         m_held = 0;
  int         m_edges = 0;
  int         m_fill_ref = 0;
  int         m_irr_start = 0;

  function automatic int decode_level(input logic [2:0] v);
    case (v)
      3'b000:  return 0;
      3'b001:  return 1;
      3'b011:  return 2;
      3'b111:  return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_step();
    int  lv, lvl;
    bit  inv, all_diff;
    if (rst) begin
      m_state  = M_IDLE;
      m_deb    = 3'b000;
      m_dvalid = 1'b0;
      m_held   = 0;
      m_edges  = 0;
      m_hist.delete();
      m_hist.push_back({H, M, L});
      return;
    end
    m_edges++;
    lv  = decode_level(m_deb);
    inv = (lv < 0);
    lvl = inv ? m_held : lv;
    case (m_state)
      M_IDLE: if (m_dvalid) begin
        if (inv)             m_state = M_ERROR;
        else if (lvl <= 1)   begin m_state = M_FILL;  m_fill_ref  = m_edges; end
        else if (irr_req)    begin m_state = M_IRRIG; m_irr_start = m_edges; end
      end
      M_FILL: begin
        if (inv)                          m_state = M_ERROR;
        else if (lvl == 3)                m_state = M_IDLE;
        else if (m_edges - m_fill_ref >= FTO) m_state = M_ERROR;
        else if (lvl > m_held)            m_fill_ref = m_edges;
      end
      M_IRRIG: begin
        if (inv)                          m_state = M_ERROR;
        else if (lvl <= 1)                m_state = M_IDLE;
        else if (m_edges - m_irr_start >= IRR) m_state = M_IDLE;
      end
      M_ERROR: if (err_clr && !inv) m_state = M_IDLE;
      default: m_state = M_IDLE;
    endcase
    if (!inv) m_held = lv;
    if (m_hist.size() >= DEB) begin
      for (int b = 0; b < 3; b++) begin
        all_diff = 1'b1;
        for (int k = m_hist.size() - DEB; k < m_hist.size(); k++)
          if (m_hist[k][b] == m_deb[b]) all_diff = 1'b0;
        if (all_diff) m_deb[b] = ~m_deb[b];
      end
    end
    m_hist.push_back({H, M, L});
    if (m_hist.size() > DEB) void'(m_hist.pop_front());
    if (m_edges >= DEB) m_dvalid = 1'b1;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (model_on) begin
      int lv;
      lv = decode_level(m_deb);
      checkOutput("model_level",     level,     (lv < 0) ? m_held : lv);
      checkOutput("model_valve_in",  valve_in,  m_state == M_FILL);
      checkOutput("model_valve_out", valve_out, m_state == M_IRRIG);
      checkOutput("model_busy",      busy,      m_state == M_FILL || m_state == M_IRRIG);
      checkOutput("model_err",       err,       m_state == M_ERROR);
    end
  end

  typedef struct {
    logic [2:0] sens;
    logic       req;
    logic       clr;
    int         cycles;
    logic       exp_vi;
    logic       exp_vo;
    logic [1:0] exp_lvl;
    logic       exp_busy;
    logic       exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input logic [2:0] s, input logic rq, input logic cl, input int n,
                                  input logic vi, input logic vo, input logic [1:0] lv,
                                  input logic bz, input logic er);
    vec_t v;
    v = '{s, rq, cl, n, vi, vo, lv, bz, er};
    vecs.push_back(v);
  endfunction

  task automatic wait_for_fill(input string name);
    int n;
    n = 0;
    while (valve_in !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, valve_in, 1);
  endtask

  task automatic clear_and_refill(input string name);
    applyStimulus(3'b001, 1'b0, 1'b1, 1);
    checkOutput({name, "_err_clr"}, err, 0);
    applyStimulus(3'b001, 1'b0, 1'b0, 0);
    wait_for_fill(name);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=%0d expected=%0d", 0, 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Sensors, request, clear, cycles -> valve_in, valve_out, level, busy, err
    add_vec(3'b000, 0, 0, 10, 1, 0, 2'd0, 1, 0);
    add_vec(3'b001, 0, 0, 10, 1, 0, 2'd1, 1, 0);
    add_vec(3'b011, 0, 0, 10, 1, 0, 2'd2, 1, 0);
    add_vec(3'b111, 0, 0, DEB + 1, 1, 0, 2'd3, 1, 0);
    add_vec(3'b111, 0, 0, 1, 0, 0, 2'd3, 0, 0);
    add_vec(3'b011, 0, 0, 10, 0, 0, 2'd2, 0, 0);
    add_vec(3'b011, 1, 0, 1, 0, 1, 2'd2, 1, 0);
    add_vec(3'b011, 0, 0, IRR - 1, 0, 1, 2'd2, 1, 0);
    add_vec(3'b011, 0, 0, 1, 0, 0, 2'd2, 0, 0);
    add_vec(3'b011, 1, 0, 1, 0, 1, 2'd2, 1, 0);
    add_vec(3'b011, 1, 0, IRR, 0, 0, 2'd2, 0, 0);
    add_vec(3'b011, 1, 0, 1, 0, 1, 2'd2, 1, 0);
    add_vec(3'b001, 0, 0, DEB + 1, 0, 1, 2'd1, 1, 0);
    add_vec(3'b001, 0, 0, 1, 0, 0, 2'd1, 0, 0);
    add_vec(3'b001, 0, 0, 1, 1, 0, 2'd1, 1, 0);
    add_vec(3'b101, 0, 0, DEB + 2, 0, 0, 2'd1, 0, 1);
    add_vec(3'b101, 0, 1, 2, 0, 0, 2'd1, 0, 1);
    add_vec(3'b111, 0, 0, DEB + 1, 0, 0, 2'd3, 0, 1);
    add_vec(3'b111, 0, 1, 1, 0, 0, 2'd3, 0, 0);
    add_vec(3'b111, 0, 0, 1, 0, 0, 2'd3, 0, 0);

    rst = 1'b1;
    applyStimulus(3'b111, 1'b0, 1'b0, 2);
    checkOutput("reset_valve_in", valve_in, 0);
    checkOutput("reset_valve_out", valve_out, 0);
    checkOutput("reset_level", level, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_err", err, 0);
    model_on = 1'b1;

    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput($sformatf("startup_busy_c%0d", c), busy, 0);
    end
    checkOutput("startup_level", level, 3);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].sens, vecs[i].req, vecs[i].clr, vecs[i].cycles);
      checkOutput($sformatf("vec%0d_valve_in", i),  valve_in,  vecs[i].exp_vi);
      checkOutput($sformatf("vec%0d_valve_out", i), valve_out, vecs[i].exp_vo);
      checkOutput($sformatf("vec%0d_level", i),     level,     vecs[i].exp_lvl);
      checkOutput($sformatf("vec%0d_busy", i),      busy,      vecs[i].exp_busy);
      checkOutput($sformatf("vec%0d_err", i),       err,       vecs[i].exp_err);
    end

    // Stuck at LOW: timeout counted from FILL entry.
    applyStimulus(3'b001, 1'b0, 1'b0, 0);
    wait_for_fill("toA_entry");
    applyStimulus(3'b001, 1'b0, 1'b0, FTO - 1);
    checkOutput("toA_before_err", err, 0);
    checkOutput("toA_before_vi", valve_in, 1);
    applyStimulus(3'b001, 1'b0, 1'b0, 1);
    checkOutput("toA_at_err", err, 1);
    checkOutput("toA_at_vi", valve_in, 0);

    // Short glitch to MID must not restart the timeout.
    clear_and_refill("toB_entry");
    applyStimulus(3'b001, 1'b0, 1'b0, 10);
    applyStimulus(3'b011, 1'b0, 1'b0, DEB - 1);
    applyStimulus(3'b001, 1'b0, 1'b0, FTO - 1 - 10 - (DEB - 1));
    checkOutput("toB_before_err", err, 0);
    checkOutput("toB_level", level, 1);
    applyStimulus(3'b001, 1'b0, 1'b0, 1);
    checkOutput("toB_at_err", err, 1);

    // A full-length MID hold is a real level increase and restarts the timeout.
    clear_and_refill("toC_entry");
    applyStimulus(3'b001, 1'b0, 1'b0, 10);
    applyStimulus(3'b011, 1'b0, 1'b0, DEB);
    applyStimulus(3'b001, 1'b0, 1'b0, FTO + 1);
    checkOutput("toC_before_err", err, 0);
    checkOutput("toC_before_vi", valve_in, 1);
    applyStimulus(3'b001, 1'b0, 1'b0, 1);
    checkOutput("toC_at_err", err, 1);

    // Reset while filling closes the inlet on the next edge.
    clear_and_refill("rstfill_entry");
    rst = 1'b1;
    applyStimulus(3'b001, 1'b0, 1'b0, 1);
    checkOutput("rstfill_valve_in", valve_in, 0);
    checkOutput("rstfill_busy", busy, 0);
    checkOutput("rstfill_level", level, 0);
    rst = 1'b0;

    for (int s = 0; s < 300; s++) begin
      logic [2:0] sens;
      int         hold;
      bit         do_rst;
      case ($urandom_range(0, 19))
        0, 1, 2:          sens = 3'($urandom_range(0, 7));
        3, 4, 5, 6:       sens = 3'b000;
        7, 8, 9, 10:      sens = 3'b001;
        11, 12, 13, 14:   sens = 3'b011;
        default:          sens = 3'b111;
      endcase
      hold   = ($urandom_range(0, 9) == 0) ? $urandom_range(40, 80) : $urandom_range(1, 12);
      do_rst = ($urandom_range(0, 99) < 2);
      rst    = do_rst;
      applyStimulus(sens, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 3), do_rst ? 1 : hold);
      rst = 1'b0;
    end

    model_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
